// File: rtl/alu_shift_sequencer.sv
// Multi-cycle left shifter: shifts a left by b, one bit per clock, filling the LSB with aluflagin.
// Valid/ready on both sides; one operation in flight at a time.
module alu_shift_sequencer #(
    parameter int ancho = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ancho-1:0] a,
    input  logic [ancho-1:0] b,
    input  logic             aluflagin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ancho-1:0] aluresult,
    output logic             aluflags,
    output logic             zero
);

    localparam int CW = $clog2(ancho + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ancho:0]  SAT  = (ancho + 1)'(ancho + 1);
    localparam logic [CW-1:0]   ZERO = '0;
    localparam logic [CW-1:0]   ONE  = CW'(1);

    logic [1:0]       state_q, state_d;
    logic [ancho-1:0] sh_q, sh_d;
    logic             fill_q, fill_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [ancho:0]   b_ext;
    logic [ancho:0]   n_sat;

    assign accept = (state_q == S_IDLE) && in_valid;

    // Any shift beyond ancho+1 produces the same all-fill result, so clamp the step count.
    assign b_ext = {1'b0, b};
    assign n_sat = (b_ext > SAT) ? SAT : b_ext;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        fill_d  = fill_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sh_d    = a;
                    fill_d  = aluflagin;
                    carry_d = 1'b0;
                    cnt_d   = n_sat[CW-1:0];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A zero count finishes without touching the register, giving latency 1+n.
                if (cnt_q == ZERO) begin
                    state_d = S_DONE;
                end else begin
                    carry_d = sh_q[ancho-1];
                    sh_d    = {sh_q[ancho-2:0], fill_q};
                    cnt_d   = cnt_q - ONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            fill_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            fill_q  <= fill_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign aluresult = sh_q;
    assign aluflags  = carry_q;
    assign zero      = (sh_q == '0);

    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed and randomized bench for alu_shift_sequencer (ancho=4), latency measured from the accept edge.
module tb_alu_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       aluflagin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] aluresult;
    logic       aluflags;
    logic       zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_shift_sequencer #(.ancho(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluflagin (aluflagin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluresult (aluresult),
        .aluflags  (aluflags),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns #1 after the accept edge, with the request withdrawn.
    task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic fv);
        int k;
        a = av;
        b = bv;
        aluflagin = fv;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        aluflagin = 1'($urandom);
    endtask

    task automatic wait_result(input string tag, input int lat, input logic [3:0] er,
                               input logic ec);
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_res"}, {28'b0, aluresult}, {28'b0, er});
        chk({tag, "_carry"}, {31'b0, aluflags}, {31'b0, ec});
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, (er == 4'b0)});
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_idle", {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    // Reference: widen, shift, OR in n fill bits; carry is the bit just above the field.
    task automatic model(input logic [3:0] av, input logic [3:0] bv, input logic fv,
                         output logic [3:0] r, output logic c, output int lat);
        int n;
        logic [63:0] w;
        n = (bv > 4'd5) ? 5 : int'(bv);
        w = {60'b0, av} << n;
        if (fv) w = w | ((64'd1 << n) - 64'd1);
        r = w[3:0];
        c = (n == 0) ? 1'b0 : w[4];
        lat = n + 1;
    endtask

    initial begin
        logic [3:0] ra, rb, er;
        logic rf, ec;
        int lat;

        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {28'b0, aluresult}, 32'd0);
        chk("rst_flags", {31'b0, aluflags}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(4'b1011, 4'd1, 1'b0);
        wait_result("t1", 2, 4'b0110, 1'b1);
        release_out();

        send(4'b1011, 4'd0, 1'b0);
        wait_result("t2a", 1, 4'b1011, 1'b0);
        release_out();
        send(4'b0000, 4'd2, 1'b0);
        wait_result("t2b", 3, 4'b0000, 1'b0);
        release_out();

        send(4'b1000, 4'd4, 1'b1);
        wait_result("t3a", 5, 4'b1111, 1'b0);
        release_out();
        send(4'b1000, 4'd15, 1'b1);
        wait_result("t3b", 6, 4'b1111, 1'b1);
        release_out();
        send(4'b0110, 4'd5, 1'b0);
        wait_result("t3c", 6, 4'b0000, 1'b0);
        release_out();

        // Backpressure with a competing request pending.
        send(4'b1011, 4'd1, 1'b0);
        wait_result("t4", 2, 4'b0110, 1'b1);
        a = 4'b0001;
        b = 4'd2;
        aluflagin = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("t4_hold_res", {28'b0, aluresult}, 32'b0110);
            chk("t4_hold_carry", {31'b0, aluflags}, 32'd1);
            chk("t4_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        release_out();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t4_pend_busy", {31'b0, in_ready}, 32'd0);
        wait_result("t4_pend", 3, 4'b0111, 1'b0);
        release_out();

        // Asynchronous reset mid-shift.
        send(4'b0111, 4'd3, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_ready", {31'b0, in_ready}, 32'd1);
        chk("t5_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_result", {28'b0, aluresult}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("t5_no_valid", {31'b0, out_valid}, 32'd0);
        end
        send(4'b0111, 4'd3, 1'b0);
        wait_result("t5_next", 4, 4'b1000, 1'b1);
        release_out();

        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rf = 1'($urandom);
            model(ra, rb, rf, er, ec, lat);
            send(ra, rb, rf);
            wait_result("rnd", lat, er, ec);
            release_out();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
